// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED frame receive controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package led_ctrl_pkg;

    // Receive sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_OFS_HI = 3'd2,
        ST_OFS_LO = 3'd3,
        ST_DATA   = 3'd4,
        ST_DROP   = 3'd5
    } state_t;

    // First payload byte of a command frame.
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_SWAP  = 8'h02;

    // Address and EtherType defaults.
    localparam logic [15:0] DEFAULT_ETH_TYPE  = 16'h88B5;
    localparam logic [47:0] DEFAULT_LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BROADCAST_MAC     = 48'hFF_FF_FF_FF_FF_FF;

    // A frame is ours if it is addressed to us or to everyone and carries our EtherType.
    function automatic logic frame_accepted(
        input logic [47:0] dest_mac,
        input logic [47:0] local_mac,
        input logic [15:0] eth_type,
        input logic [15:0] want_type
    );
        frame_accepted = ((dest_mac == local_mac) || (dest_mac == BROADCAST_MAC))
                         && (eth_type == want_type);
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// Saturating 16-bit event counter, sticks at 16'hFFFF.
// Latency: count reflects an enable pulse on the following clock edge.
// Backpressure: none; one increment per enabled cycle.
module sat_counter16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] count
);

    // Count enabled cycles, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/led_frame_rx_ctrl.sv
// Filters command frames and writes pixel bytes into the back bank of a double-buffered framebuffer; swaps banks at vsync.
// Latency: a payload byte appears on the framebuffer write port one cycle after it is accepted.
// Backpressure: headers stall while a swap is pending or a frame is in progress; payload is always accepted outside IDLE.
module led_frame_rx_ctrl
    import led_ctrl_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC     = DEFAULT_LOCAL_MAC,
    parameter logic [15:0] ETH_TYPE      = DEFAULT_ETH_TYPE,
    parameter int          FB_ADDR_WIDTH = 13,
    parameter int          FRAME_BYTES   = 6144
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     s_eth_hdr_valid,
    output logic                     s_eth_hdr_ready,
    input  logic [47:0]              s_eth_dest_mac,
    input  logic [15:0]              s_eth_type,

    input  logic [7:0]               s_eth_payload_axis_tdata,
    input  logic                     s_eth_payload_axis_tvalid,
    output logic                     s_eth_payload_axis_tready,
    input  logic                     s_eth_payload_axis_tlast,
    input  logic                     s_eth_payload_axis_tuser,

    output logic                     fb_wr_en,
    output logic                     fb_wr_bank,
    output logic [FB_ADDR_WIDTH-1:0] fb_wr_addr,
    output logic [7:0]               fb_wr_data,

    input  logic                     disp_vsync,
    output logic                     disp_bank,
    output logic                     swap_pending,

    output logic [15:0]              stat_frames_ok,
    output logic [15:0]              stat_frames_drop
);

    // The write pointer is one bit wider than the 16-bit offset so that
    // running past the end of the bank never wraps back into valid pixels.
    localparam int               PTR_W       = 17;
    localparam logic [PTR_W-1:0] FRAME_LIMIT = PTR_W'(FRAME_BYTES);
    localparam logic [PTR_W-1:0] PTR_MAX     = {PTR_W{1'b1}};

    state_t           state;
    state_t           state_nxt;

    logic             hdr_fire;
    logic             beat;
    logic             hdr_match;

    logic             ok_inc;
    logic             drop_inc;
    logic             swap_set;
    logic             ofs_hi_ld;
    logic             ofs_lo_ld;
    logic             data_beat;

    logic [7:0]       ofs_hi;
    logic [PTR_W-1:0] wr_ptr;
    logic             wr_in_range;

    // Headers are only taken between frames, and not while a swap waits for
    // vsync, so no pixel lands in a bank that is about to become visible.
    assign s_eth_hdr_ready           = (state == ST_IDLE) && !swap_pending;
    assign s_eth_payload_axis_tready = (state != ST_IDLE);

    assign hdr_fire    = s_eth_hdr_valid && s_eth_hdr_ready;
    assign beat        = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
    assign hdr_match   = frame_accepted(s_eth_dest_mac, LOCAL_MAC, s_eth_type, ETH_TYPE);
    assign wr_in_range = (wr_ptr < FRAME_LIMIT);

    // Writes always target the bank the scanner is not showing.
    assign fb_wr_bank  = ~disp_bank;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the per-beat strobes for datapath and statistics.
    always_comb begin
        state_nxt = state;
        ok_inc    = 1'b0;
        drop_inc  = 1'b0;
        swap_set  = 1'b0;
        ofs_hi_ld = 1'b0;
        ofs_lo_ld = 1'b0;
        data_beat = 1'b0;

        case (state)
            ST_IDLE: begin
                if (hdr_fire) begin
                    if (hdr_match) begin
                        state_nxt = ST_CMD;
                    end else begin
                        drop_inc  = 1'b1;
                        state_nxt = ST_DROP;
                    end
                end
            end

            ST_CMD: begin
                if (beat) begin
                    if (s_eth_payload_axis_tdata == CMD_WRITE) begin
                        if (s_eth_payload_axis_tlast) begin
                            drop_inc  = 1'b1;
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_OFS_HI;
                        end
                    end else if (s_eth_payload_axis_tdata == CMD_SWAP) begin
                        swap_set  = 1'b1;
                        ok_inc    = 1'b1;
                        state_nxt = s_eth_payload_axis_tlast ? ST_IDLE : ST_DROP;
                    end else begin
                        drop_inc  = 1'b1;
                        state_nxt = s_eth_payload_axis_tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end

            ST_OFS_HI: begin
                if (beat) begin
                    if (s_eth_payload_axis_tlast) begin
                        drop_inc  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ofs_hi_ld = 1'b1;
                        state_nxt = ST_OFS_LO;
                    end
                end
            end

            ST_OFS_LO: begin
                if (beat) begin
                    if (s_eth_payload_axis_tlast) begin
                        drop_inc  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ofs_lo_ld = 1'b1;
                        state_nxt = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (beat) begin
                    data_beat = 1'b1;
                    if (s_eth_payload_axis_tlast) begin
                        // Bytes already written stay; only the statistic reflects the bad flag.
                        ok_inc    = !s_eth_payload_axis_tuser;
                        drop_inc  = s_eth_payload_axis_tuser;
                        state_nxt = ST_IDLE;
                    end
                end
            end

            ST_DROP: begin
                if (beat && s_eth_payload_axis_tlast) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Offset capture and the running byte pointer for the current WRITE frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofs_hi <= 8'h00;
            wr_ptr <= '0;
        end else begin
            if (ofs_hi_ld) begin
                ofs_hi <= s_eth_payload_axis_tdata;
            end
            if (ofs_lo_ld) begin
                wr_ptr <= {1'b0, ofs_hi, s_eth_payload_axis_tdata};
            end else if (data_beat && (wr_ptr != PTR_MAX)) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    // Registered framebuffer write port; out-of-range bytes are consumed silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= 8'h00;
        end else begin
            fb_wr_en <= data_beat && wr_in_range;
            if (data_beat) begin
                fb_wr_addr <= wr_ptr[FB_ADDR_WIDTH-1:0];
                fb_wr_data <= s_eth_payload_axis_tdata;
            end
        end
    end

    // Bank swap: a pending swap completes on vsync; a SWAP accepted in the
    // same cycle as vsync only arms the swap for the next vsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bank    <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (disp_vsync && swap_pending) begin
                disp_bank <= ~disp_bank;
            end
            swap_pending <= swap_set || (swap_pending && !disp_vsync);
        end
    end

    sat_counter16 u_stat_ok (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ok_inc),
        .count (stat_frames_ok)
    );

    sat_counter16 u_stat_drop (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (drop_inc),
        .count (stat_frames_drop)
    );

endmodule

// File: tb/tb_led_frame_rx_ctrl.sv
// Randomised frame stimulus against a frame-level reference model with a write scoreboard.
// Latency: expects each data byte on the write port one cycle after acceptance.
// Backpressure: drives valid and waits (bounded) on hdr_ready / tready.
module tb_led_frame_rx_ctrl;

    localparam logic [47:0] LMAC    = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] FOREIGN = 48'h02_00_00_00_00_02;
    localparam logic [15:0] ETYPE   = 16'h88B5;
    localparam logic [15:0] IPV4    = 16'h0800;
    localparam int          NBYTES  = 6144;
    localparam int          BOUND   = 1000;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic        bank;
        logic [12:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_eth_hdr_valid;
    logic        s_eth_hdr_ready;
    logic [47:0] s_eth_dest_mac;
    logic [15:0] s_eth_type;
    logic [7:0]  s_eth_payload_axis_tdata;
    logic        s_eth_payload_axis_tvalid;
    logic        s_eth_payload_axis_tready;
    logic        s_eth_payload_axis_tlast;
    logic        s_eth_payload_axis_tuser;
    logic        fb_wr_en;
    logic        fb_wr_bank;
    logic [12:0] fb_wr_addr;
    logic [7:0]  fb_wr_data;
    logic        disp_vsync;
    logic        disp_bank;
    logic        swap_pending;
    logic [15:0] stat_frames_ok;
    logic [15:0] stat_frames_drop;

    led_frame_rx_ctrl dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_eth_payload_axis_tdata),
        .s_eth_payload_axis_tvalid (s_eth_payload_axis_tvalid),
        .s_eth_payload_axis_tready (s_eth_payload_axis_tready),
        .s_eth_payload_axis_tlast  (s_eth_payload_axis_tlast),
        .s_eth_payload_axis_tuser  (s_eth_payload_axis_tuser),
        .fb_wr_en                  (fb_wr_en),
        .fb_wr_bank                (fb_wr_bank),
        .fb_wr_addr                (fb_wr_addr),
        .fb_wr_data                (fb_wr_data),
        .disp_vsync                (disp_vsync),
        .disp_bank                 (disp_bank),
        .swap_pending              (swap_pending),
        .stat_frames_ok            (stat_frames_ok),
        .stat_frames_drop          (stat_frames_drop)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  passes = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    // Reference model state: frame-level view of counters and banks.
    int  m_ok      = 0;
    int  m_drop    = 0;
    bit  m_bank    = 1'b0;
    bit  m_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic summary_and_finish();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    task automatic timeout(input string name);
        checks++;
        $display("FAIL %s: no handshake within %0d cycles, required one", name, BOUND);
        summary_and_finish();
    endtask

    // Scoreboard monitor: every write the DUT issues must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && fb_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got bank %0b addr %0h data %0h, required no write",
                         fb_wr_bank, fb_wr_addr, fb_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_bank", 64'(fb_wr_bank), 64'(mon_e.bank));
                check("wr_addr", 64'(fb_wr_addr), 64'(mon_e.addr));
                check("wr_data", 64'(fb_wr_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    task automatic m_inc_ok();
        if (m_ok < 65535) m_ok++;
    endtask

    task automatic m_inc_drop();
        if (m_drop < 65535) m_drop++;
    endtask

    task automatic model_vsync();
        if (m_pending) begin
            m_bank    = ~m_bank;
            m_pending = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [47:0] dest, input logic [15:0] etype,
                               input bq_t bytes, input bit tuser);
        int off;
        int a;
        wr_t w;
        if (!((dest == LMAC || dest == BCAST) && etype == ETYPE)) begin
            m_inc_drop();
            return;
        end
        if (bytes[0] == 8'h02) begin
            m_pending = 1'b1;
            m_inc_ok();
            return;
        end
        if (bytes[0] != 8'h01 || bytes.size() <= 3) begin
            m_inc_drop();
            return;
        end
        off = int'({bytes[1], bytes[2]});
        for (int i = 3; i < bytes.size(); i++) begin
            a = off + i - 3;
            if (a < NBYTES) begin
                w.bank = ~m_bank;
                w.addr = 13'(a);
                w.data = bytes[i];
                exp_q.push_back(w);
            end
        end
        if (tuser) m_inc_drop();
        else m_inc_ok();
    endtask

    // ---------------- drivers ----------------
    task automatic drive_hdr(input logic [47:0] dest, input logic [15:0] etype);
        int n = 0;
        s_eth_hdr_valid = 1'b1;
        s_eth_dest_mac  = dest;
        s_eth_type      = etype;
        while (!s_eth_hdr_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > BOUND) timeout("hdr_handshake");
        end
        @(posedge clk); #1;
        s_eth_hdr_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [7:0] d, input bit last, input bit user);
        int n = 0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
        s_eth_payload_axis_tvalid = 1'b1;
        s_eth_payload_axis_tdata  = d;
        s_eth_payload_axis_tlast  = last;
        // tuser is only meaningful on the last beat; noise elsewhere must be ignored.
        s_eth_payload_axis_tuser  = last ? user : 1'($urandom_range(0, 1));
        while (!s_eth_payload_axis_tready) begin
            @(posedge clk); #1;
            n++;
            if (n > BOUND) timeout("payload_handshake");
        end
        @(posedge clk); #1;
        s_eth_payload_axis_tvalid = 1'b0;
        s_eth_payload_axis_tlast  = 1'b0;
        s_eth_payload_axis_tuser  = 1'b0;
    endtask

    task automatic xmit_frame(input logic [47:0] dest, input logic [15:0] etype,
                              input bq_t bytes, input bit tuser);
        drive_hdr(dest, etype);
        for (int i = 0; i < bytes.size(); i++) begin
            drive_beat(bytes[i], i == bytes.size() - 1, tuser);
        end
    endtask

    task automatic drive_vsync();
        disp_vsync = 1'b1;
        @(posedge clk); #1;
        disp_vsync = 1'b0;
    endtask

    task automatic pulse_vsync();
        model_vsync();
        drive_vsync();
    endtask

    task automatic settle_check(input string tag);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check({tag, "_ok"},      64'(stat_frames_ok),   64'(m_ok));
        check({tag, "_drop"},    64'(stat_frames_drop), 64'(m_drop));
        check({tag, "_bank"},    64'(disp_bank),        64'(m_bank));
        check({tag, "_pending"}, 64'(swap_pending),     64'(m_pending));
        check({tag, "_wr_left"}, 64'(exp_q.size()),     64'd0);
    endtask

    task automatic send_frame(input string tag, input logic [47:0] dest, input logic [15:0] etype,
                              input bq_t bytes, input bit tuser);
        model_frame(dest, etype, bytes, tuser);
        xmit_frame(dest, etype, bytes, tuser);
        settle_check(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"},   64'(fb_wr_en),                  64'd0);
        check({tag, "_addr"},    64'(fb_wr_addr),                64'd0);
        check({tag, "_data"},    64'(fb_wr_data),                64'd0);
        check({tag, "_bank"},    64'(disp_bank),                 64'd0);
        check({tag, "_pending"}, 64'(swap_pending),              64'd0);
        check({tag, "_ok"},      64'(stat_frames_ok),            64'd0);
        check({tag, "_drop"},    64'(stat_frames_drop),          64'd0);
        check({tag, "_tready"},  64'(s_eth_payload_axis_tready), 64'd0);
        check({tag, "_hdr_rdy"}, 64'(s_eth_hdr_ready),           64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bq_t         b;
        logic [47:0] dest;
        logic [15:0] etype;
        int          ofs;
        int          len;
        int          c;
        bit          tu;
        wr_t         w;

        rst_n                     = 1'b0;
        s_eth_hdr_valid           = 1'b0;
        s_eth_dest_mac            = '0;
        s_eth_type                = '0;
        s_eth_payload_axis_tdata  = '0;
        s_eth_payload_axis_tvalid = 1'b0;
        s_eth_payload_axis_tlast  = 1'b0;
        s_eth_payload_axis_tuser  = 1'b0;
        disp_vsync                = 1'b0;

        #22;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: plain WRITE into the back bank.
        b = '{8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame("t1_write", LMAC, ETYPE, b, 1'b0);

        // 2: wrong MAC, then wrong EtherType.
        b = '{8'h01, 8'h00, 8'h00, 8'h11, 8'h22};
        send_frame("t2_foreign_mac", FOREIGN, ETYPE, b, 1'b0);
        send_frame("t2_bad_type", LMAC, IPV4, b, 1'b0);

        // 3: SWAP, then a WRITE that must wait for vsync and land in the other bank.
        b = '{8'h02};
        send_frame("t3_swap", BCAST, ETYPE, b, 1'b0);
        b = '{8'h01, 8'h00, 8'h40, 8'h5A, 8'hA5};
        model_vsync();
        model_frame(LMAC, ETYPE, b, 1'b0);
        fork
            xmit_frame(LMAC, ETYPE, b, 1'b0);
            begin
                repeat (5) begin
                    @(posedge clk); #1;
                    check("t3_hdr_ready_pending", 64'(s_eth_hdr_ready), 64'd0);
                end
                drive_vsync();
            end
        join
        settle_check("t3_write_after_swap");

        // 4: WRITE straddling the end of the bank.
        b = '{8'h01, 8'h17, 8'hFE, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame("t4_boundary", LMAC, ETYPE, b, 1'b0);

        // 5: bad-frame flag on a WRITE, then a frame truncated after the high offset byte.
        b = '{8'h01, 8'h01, 8'h00, 8'h31, 8'h32, 8'h33};
        send_frame("t5_tuser", LMAC, ETYPE, b, 1'b1);
        b = '{8'h01, 8'h02};
        send_frame("t5_truncated", LMAC, ETYPE, b, 1'b0);

        // Random frames.
        for (int f = 0; f < 30; f++) begin
            if (m_pending || $urandom_range(0, 4) == 0) pulse_vsync();
            c     = $urandom_range(0, 99);
            dest  = (c < 10) ? FOREIGN : (c < 25) ? BCAST : LMAC;
            etype = ($urandom_range(0, 9) == 0) ? IPV4 : ETYPE;
            tu    = ($urandom_range(0, 4) == 0);
            b.delete();
            c = $urandom_range(0, 9);
            if (c < 6) begin
                ofs = ($urandom_range(0, 1) == 1) ? $urandom_range(6130, 6150)
                                                  : $urandom_range(0, NBYTES - 1);
                len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3)
                                                  : 3 + $urandom_range(1, 12);
                b.push_back(8'h01);
                b.push_back(8'(ofs >> 8));
                b.push_back(8'(ofs));
                while (b.size() > len) void'(b.pop_back());
                while (b.size() < len) b.push_back(8'($urandom_range(0, 255)));
            end else begin
                b.push_back((c < 8) ? 8'h02 : 8'($urandom_range(0, 255)));
                len = $urandom_range(1, 4);
                while (b.size() < len) b.push_back(8'($urandom_range(0, 255)));
            end
            send_frame("rand", dest, etype, b, tu);
        end

        // 6: SWAP accepted in the same cycle as vsync arms, but does not complete, the swap.
        if (m_pending) pulse_vsync();
        drive_hdr(LMAC, ETYPE);
        model_vsync();
        b = '{8'h02};
        model_frame(LMAC, ETYPE, b, 1'b0);
        s_eth_payload_axis_tvalid = 1'b1;
        s_eth_payload_axis_tdata  = 8'h02;
        s_eth_payload_axis_tlast  = 1'b1;
        disp_vsync                = 1'b1;
        while (!s_eth_payload_axis_tready) begin
            disp_vsync = 1'b0;
            @(posedge clk); #1;
            disp_vsync = 1'b1;
        end
        @(posedge clk); #1;
        s_eth_payload_axis_tvalid = 1'b0;
        s_eth_payload_axis_tlast  = 1'b0;
        disp_vsync                = 1'b0;
        settle_check("t6_swap_on_vsync");
        pulse_vsync();
        settle_check("t6_next_vsync");

        // Reset in the middle of DATA: partial writes stay, nothing after reset.
        drive_hdr(LMAC, ETYPE);
        drive_beat(8'h01, 1'b0, 1'b0);
        drive_beat(8'h00, 1'b0, 1'b0);
        drive_beat(8'h20, 1'b0, 1'b0);
        w.bank = ~m_bank; w.addr = 13'h0020; w.data = 8'hAA;
        exp_q.push_back(w);
        drive_beat(8'hAA, 1'b0, 1'b0);
        w.bank = ~m_bank; w.addr = 13'h0021; w.data = 8'hBB;
        exp_q.push_back(w);
        drive_beat(8'hBB, 1'b0, 1'b0);
        s_eth_payload_axis_tvalid = 1'b1;
        s_eth_payload_axis_tdata  = 8'hCC;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        check("mid_reset_wr_left", 64'(exp_q.size()), 64'd0);
        s_eth_payload_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        m_ok      = 0;
        m_drop    = 0;
        m_bank    = 1'b0;
        m_pending = 1'b0;
        @(posedge clk); #1;

        // Recovery after reset.
        b = '{8'h01, 8'h00, 8'h05, 8'h77, 8'h88};
        send_frame("post_reset", LMAC, ETYPE, b, 1'b0);

        summary_and_finish();
    end

endmodule
